// File: rtl/glyph_fetch_pipeline.sv
// Text-overlay front end: maps pixel x/y to a font_rom bit address through a character buffer,
// with post-reset buffer clear, per-character blink and sync delay matched to the font_rom output.
module glyph_fetch_pipeline #(
  parameter int TEXT_COLS    = 16,
  parameter int TEXT_ROWS    = 4,
  parameter int ORIGIN_X     = 64,
  parameter int ORIGIN_Y     = 32,
  parameter int SCALE_LOG2   = 1,
  parameter int ROM_LATENCY  = 1,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        HDMI_TX_CLK,
  input  logic        reset_n,
  input  logic        HDMI_TX_DE,
  input  logic        HDMI_TX_HS,
  input  logic        HDMI_TX_VS,
  input  logic [11:0] x_counter,
  input  logic [11:0] y_counter,
  input  logic        char_wr_en,
  input  logic [5:0]  char_wr_addr,
  input  logic [6:0]  char_wr_code,
  output logic [12:0] rom_address,
  output logic        overlay_enable,
  output logic        de_out,
  output logic        hs_out,
  output logic        vs_out,
  output logic        clear_busy
);

  localparam int NUM_CHARS = TEXT_COLS * TEXT_ROWS;
  localparam int IDX_W     = $clog2(NUM_CHARS);
  localparam int COL_W     = $clog2(TEXT_COLS);
  localparam int ROW_W     = $clog2(TEXT_ROWS);
  localparam int FC_W      = $clog2(BLINK_FRAMES);

  localparam logic [11:0]      ORG_X       = 12'(ORIGIN_X);
  localparam logic [11:0]      ORG_Y       = 12'(ORIGIN_Y);
  localparam logic [11:0]      WIN_W       = 12'((TEXT_COLS * 8) << SCALE_LOG2);
  localparam logic [11:0]      WIN_H       = 12'((TEXT_ROWS * 16) << SCALE_LOG2);
  localparam logic [6:0]       NUM_CHARS_7 = 7'(NUM_CHARS);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_CHARS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
  localparam logic [FC_W-1:0]  FC_LAST     = FC_W'(BLINK_FRAMES - 1);
  localparam logic [FC_W-1:0]  FC_ONE      = FC_W'(1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // ---------------- combinational pixel decode ----------------
  logic [11:0]      rx_s, ry_s, gx_s, gy_s;
  logic             inwin_s;
  logic [IDX_W-1:0] idx_s;
  logic             unused_ok_s;

  assign rx_s    = x_counter - ORG_X;
  assign ry_s    = y_counter - ORG_Y;
  assign inwin_s = HDMI_TX_DE & (x_counter >= ORG_X) & (rx_s < WIN_W)
                 & (y_counter >= ORG_Y) & (ry_s < WIN_H);
  assign gx_s    = rx_s >> SCALE_LOG2;
  assign gy_s    = ry_s >> SCALE_LOG2;
  // Power-of-two geometry lets the row*COLS+col index be a plain concatenation.
  assign idx_s   = {gy_s[4 +: ROW_W], gx_s[3 +: COL_W]};
  assign unused_ok_s = ^{gx_s[11:3+COL_W], gy_s[11:4+ROW_W]};

  // ---------------- S0: input capture ----------------
  logic             inwin_s0_q;
  logic [IDX_W-1:0] idx_s0_q;
  logic [3:0]       grow_s0_q;
  logic [2:0]       gcol_s0_q;
  logic [2:0]       sync_s0_q;

  // Stage 0 register: window flag, buffer index, glyph coordinates, syncs
  always_ff @(posedge HDMI_TX_CLK or negedge reset_n) begin
    if (!reset_n) begin
      inwin_s0_q <= 1'b0;
      idx_s0_q   <= '0;
      grow_s0_q  <= 4'd0;
      gcol_s0_q  <= 3'd0;
      sync_s0_q  <= 3'd0;
    end else begin
      inwin_s0_q <= inwin_s;
      idx_s0_q   <= idx_s;
      grow_s0_q  <= gy_s[3:0];
      gcol_s0_q  <= gx_s[2:0];
      sync_s0_q  <= {HDMI_TX_DE, HDMI_TX_HS, HDMI_TX_VS};
    end
  end

  // ---------------- clear / run FSM ----------------
  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic             clear_busy_q;
  logic             mem_we_s;
  logic [IDX_W-1:0] mem_waddr_s;
  logic [6:0]       mem_wdata_s;
  logic             wr_in_range_s;

  assign wr_in_range_s = ({1'b0, char_wr_addr} < NUM_CHARS_7);

  // FSM next-state and buffer write-port selection
  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = char_wr_addr[IDX_W-1:0];
    mem_wdata_s = char_wr_code;
    case (state_q)
      ST_CLEAR: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = clr_idx_q;
        mem_wdata_s = 7'd0;
        if (clr_idx_q == IDX_LAST) begin
          state_d = ST_RUN;
        end else begin
          clr_idx_d = clr_idx_q + IDX_ONE;
        end
      end
      ST_RUN: begin
        if (char_wr_en && wr_in_range_s) begin
          mem_we_s = 1'b1;
        end else begin
          mem_we_s = 1'b0;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_idx_d = '0;
      end
    endcase
  end

  // FSM state, clear index and busy flag
  always_ff @(posedge HDMI_TX_CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_CLEAR;
      clr_idx_q    <= '0;
      clear_busy_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      clear_busy_q <= (state_d == ST_CLEAR);
    end
  end

  // ---------------- character buffer ----------------
  // Not reset: contents are zeroed by the clear sequence instead.
  logic [6:0] mem_q [NUM_CHARS];

  // Buffer write port
  always_ff @(posedge HDMI_TX_CLK) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // ---------------- S1: buffer read into rom_address ----------------
  logic [12:0] rom_address_q;
  logic [6:0]  rd_code_s;
  logic        blink_s1_q;
  logic        inwin_s1_q;
  logic [2:0]  sync_s1_q;

  // Old contents are seen when the same index is written this cycle.
  assign rd_code_s = mem_q[idx_s0_q];

  // Stage 1/2 register: synchronous buffer read feeding rom_address directly
  always_ff @(posedge HDMI_TX_CLK or negedge reset_n) begin
    if (!reset_n) begin
      rom_address_q <= 13'd0;
      blink_s1_q    <= 1'b0;
      inwin_s1_q    <= 1'b0;
      sync_s1_q     <= 3'd0;
    end else begin
      inwin_s1_q <= inwin_s0_q;
      sync_s1_q  <= sync_s0_q;
      blink_s1_q <= rd_code_s[6];
      if (inwin_s0_q) begin
        rom_address_q <= {rd_code_s[5:0], grow_s0_q, gcol_s0_q};
      end else begin
        rom_address_q <= rom_address_q;
      end
    end
  end

  // ---------------- blink timing ----------------
  logic            vs_prev_q;
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic            blink_phase_q, blink_phase_d;

  // Frame counter advance on each VS rising edge
  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (HDMI_TX_VS && !vs_prev_q) begin
      if (frame_cnt_q == FC_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FC_ONE;
      end
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Blink state registers
  always_ff @(posedge HDMI_TX_CLK or negedge reset_n) begin
    if (!reset_n) begin
      vs_prev_q     <= 1'b0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      vs_prev_q     <= HDMI_TX_VS;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // ---------------- output alignment with font_rom q ----------------
  logic       en_s;
  logic [3:0] out_pipe_q [ROM_LATENCY];

  assign en_s = inwin_s1_q & ~clear_busy_q & ~(blink_s1_q & ~blink_phase_q);

  // Delay line matching the font_rom read latency
  always_ff @(posedge HDMI_TX_CLK or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ROM_LATENCY; i++) begin
        out_pipe_q[i] <= 4'd0;
      end
    end else begin
      out_pipe_q[0] <= {en_s, sync_s1_q};
      for (int i = 1; i < ROM_LATENCY; i++) begin
        out_pipe_q[i] <= out_pipe_q[i-1];
      end
    end
  end

  assign rom_address    = rom_address_q;
  assign overlay_enable = out_pipe_q[ROM_LATENCY-1][3];
  assign de_out         = out_pipe_q[ROM_LATENCY-1][2];
  assign hs_out         = out_pipe_q[ROM_LATENCY-1][1];
  assign vs_out         = out_pipe_q[ROM_LATENCY-1][0];
  assign clear_busy     = clear_busy_q;

endmodule

// File: tb/tb_glyph_fetch_pipeline.sv
// Directed self-checking bench for glyph_fetch_pipeline (default parameters).
module tb_glyph_fetch_pipeline;

  logic        clk;
  logic        reset_n;
  logic        de_i, hs_i, vs_i;
  logic [11:0] x_i, y_i;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [6:0]  wr_code;
  logic [12:0] rom_address;
  logic        overlay_enable, de_out, hs_out, vs_out, clear_busy;

  int checks   = 0;
  int failures = 0;

  glyph_fetch_pipeline dut (
    .HDMI_TX_CLK   (clk),
    .reset_n       (reset_n),
    .HDMI_TX_DE    (de_i),
    .HDMI_TX_HS    (hs_i),
    .HDMI_TX_VS    (vs_i),
    .x_counter     (x_i),
    .y_counter     (y_i),
    .char_wr_en    (wr_en),
    .char_wr_addr  (wr_addr),
    .char_wr_code  (wr_code),
    .rom_address   (rom_address),
    .overlay_enable(overlay_enable),
    .de_out        (de_out),
    .hs_out        (hs_out),
    .vs_out        (vs_out),
    .clear_busy    (clear_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_px(input int x, input int y, input logic de);
    x_i  = 12'(x);
    y_i  = 12'(y);
    de_i = de;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int addr, input int code);
    wr_en   = 1'b1;
    wr_addr = 6'(addr);
    wr_code = 7'(code);
    tick(1);
    wr_en   = 1'b0;
  endtask

  task automatic wait_clear(input string tag);
    int cnt;
    int ovbad;
    int n;
    cnt = 0;
    ovbad = 0;
    n = 0;
    while (clear_busy && n < 300) begin
      cnt++;
      if (overlay_enable) ovbad++;
      tick(1);
      n++;
    end
    check({tag, "_len"}, 32'(cnt), 32'd64);
    check({tag, "_ov"}, 32'(ovbad), 32'd0);
  endtask

  int xs[4] = '{320, 319, 63, 319};
  int ys[4] = '{159, 160, 159, 159};
  logic des[4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int exp_i;
    reset_n = 1'b0;
    hs_i = 1'b0;
    vs_i = 1'b0;
    wr_en = 1'b0;
    wr_addr = 6'd0;
    wr_code = 7'd0;
    set_px(64, 32, 1'b1);
    tick(3);
    check("rst_rom", 32'(rom_address), 32'd0);
    check("rst_ov", 32'(overlay_enable), 32'd0);
    check("rst_syncs", 32'({de_out, hs_out, vs_out}), 32'd0);
    check("rst_busy", 32'(clear_busy), 32'd1);

    // Writes attempted during the clear must be ignored.
    wr_en = 1'b1;
    wr_addr = 6'd3;
    wr_code = 7'h11;
    reset_n = 1'b1;
    wait_clear("clear1");
    wr_en = 1'b0;
    check("de_delay", 32'(de_out), 32'd1);

    set_px(0, 0, 1'b1);
    tick(4);
    check("ov_outside", 32'(overlay_enable), 32'd0);
    wr(0, 5);
    set_px(64, 32, 1'b1);
    tick(1);
    check("lat_rom1", 32'(rom_address), 32'd0);
    tick(1);
    check("lat_rom2", 32'(rom_address), 32'd640);
    check("lat_ov2", 32'(overlay_enable), 32'd0);
    tick(1);
    check("lat_ov3", 32'(overlay_enable), 32'd1);

    set_px(112, 32, 1'b1);
    tick(3);
    check("clr_wr_ignored", 32'(rom_address), 32'd0);
    set_px(66, 34, 1'b1);
    tick(2);
    check("scale_addr", 32'(rom_address), 32'd649);
    wr(1, 10);
    set_px(80, 32, 1'b1);
    tick(2);
    check("idx1_addr", 32'(rom_address), 32'd1280);
    set_px(319, 159, 1'b1);
    tick(2);
    check("corner_addr", 32'(rom_address), 32'd127);

    for (int i = 0; i < 4; i++) begin
      set_px(xs[i], ys[i], des[i]);
      tick(3);
      check("edge_ov", 32'(overlay_enable), 32'd0);
      check("edge_hold", 32'(rom_address), 32'd127);
      set_px(319, 159, 1'b1);
      tick(3);
      check("edge_back", 32'(overlay_enable), 32'd1);
    end

    hs_i = 1'b1;
    tick(1);
    hs_i = 1'b0;
    tick(1);
    check("hs_early", 32'(hs_out), 32'd0);
    tick(1);
    check("hs_delay", 32'(hs_out), 32'd1);
    tick(1);
    check("hs_pulse", 32'(hs_out), 32'd0);

    // Write to idx2 on the edge that reads it.
    wr(2, 3);
    set_px(96, 32, 1'b1);
    tick(1);
    wr_en = 1'b1;
    wr_addr = 6'd2;
    wr_code = 7'd7;
    tick(1);
    wr_en = 1'b0;
    check("rdw_old", 32'(rom_address), 32'd384);
    tick(1);
    check("rdw_new", 32'(rom_address), 32'd896);

    wr(0, 'h45);
    set_px(64, 32, 1'b1);
    tick(3);
    check("blink_addr", 32'(rom_address), 32'd640);
    for (int f = 0; f < 90; f++) begin
      exp_i = (f >= 30 && f < 60) ? 1 : 0;
      check($sformatf("blink_f%0d", f), 32'(overlay_enable), 32'(exp_i));
      vs_i = 1'b1;
      tick(1);
      vs_i = 1'b0;
      tick(3);
    end

    // Reset mid-frame, then confirm the clear zeroed every entry.
    set_px(64, 32, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_rom", 32'(rom_address), 32'd0);
    check("mid_rst_ov", 32'(overlay_enable), 32'd0);
    check("mid_rst_de", 32'(de_out), 32'd0);
    check("mid_rst_busy", 32'(clear_busy), 32'd1);
    tick(2);
    reset_n = 1'b1;
    wait_clear("clear2");
    for (int e = 0; e < 64; e++) begin
      int row;
      int col;
      int r;
      row = e / 16;
      col = e % 16;
      r = e % 16;
      set_px(64 + col * 16 + (col % 8) * 2, 32 + row * 32 + r * 2, 1'b1);
      tick(2);
      check($sformatf("cleared_%0d", e), 32'(rom_address), 32'(r * 8 + (col % 8)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
